// File: rtl/jalu_mul_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier that borrows an external ALU
// for every add and shift; fixed 24-cycle latency regardless of operand values.
module jalu_mul_seq #(
    parameter logic [2:0] OP_ADD = 3'd0,
    parameter logic [2:0] OP_SHR = 3'd1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_ci,
    output logic [2:0]  alu_op,
    input  logic [7:0]  alu_out,
    input  logic        alu_co,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        zero,
    output logic        hi_nz
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD  = 3'd1,
        SHP  = 3'd2,
        SHQ  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  m_reg, m_next;
    logic [7:0]  p_reg, p_next;
    logic [7:0]  q_reg, q_next;
    logic        c_reg, c_next;
    logic        l_reg, l_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [15:0] product_reg, product_next;
    logic        zero_reg, zero_next;
    logic        hi_nz_reg, hi_nz_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            m_reg       <= 8'd0;
            p_reg       <= 8'd0;
            q_reg       <= 8'd0;
            c_reg       <= 1'b0;
            l_reg       <= 1'b0;
            cnt_reg     <= 3'd0;
            product_reg <= 16'd0;
            zero_reg    <= 1'b1;
            hi_nz_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            m_reg       <= m_next;
            p_reg       <= p_next;
            q_reg       <= q_next;
            c_reg       <= c_next;
            l_reg       <= l_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
            zero_reg    <= zero_next;
            hi_nz_reg   <= hi_nz_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        m_next       = m_reg;
        p_next       = p_reg;
        q_next       = q_reg;
        c_next       = c_reg;
        l_next       = l_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;
        zero_next    = zero_reg;
        hi_nz_next   = hi_nz_reg;
        alu_op       = OP_ADD;
        alu_a        = 8'd0;
        alu_b        = 8'd0;
        alu_ci       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    m_next     = a_in;
                    q_next     = b_in;
                    p_next     = 8'd0;
                    c_next     = 1'b0;
                    l_next     = 1'b0;
                    cnt_next   = 3'd0;
                    state_next = ADD;
                end
            end
            ADD: begin
                // The add is always issued so the cycle count stays data-independent;
                // its result is only kept when the current multiplier bit is set.
                alu_a = p_reg;
                alu_b = m_reg;
                if (q_reg[0]) begin
                    p_next = alu_out;
                    c_next = alu_co;
                end else begin
                    c_next = 1'b0;
                end
                state_next = SHP;
            end
            SHP: begin
                // Carry from the add re-enters at the top of P, so no bit is lost.
                alu_op     = OP_SHR;
                alu_a      = p_reg;
                alu_ci     = c_reg;
                p_next     = alu_out;
                l_next     = alu_co;
                state_next = SHQ;
            end
            SHQ: begin
                alu_op = OP_SHR;
                alu_a  = q_reg;
                alu_ci = l_reg;
                q_next = alu_out;
                if (cnt_reg == 3'd7) begin
                    product_next = {p_reg, alu_out};
                    zero_next    = ({p_reg, alu_out} == 16'd0);
                    hi_nz_next   = (p_reg != 8'd0);
                    state_next   = DONE;
                end else begin
                    cnt_next   = cnt_reg + 3'd1;
                    state_next = ADD;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign product = product_reg;
    assign zero    = zero_reg;
    assign hi_nz   = hi_nz_reg;

endmodule

// File: tb/tb_jalu_mul_seq.sv
// Bench for jalu_mul_seq: behavioural ALU, cycle-level model from arithmetic,
// per-cycle output and ALU-drive monitor, plus directed literal checks.
module tb_jalu_mul_seq;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a_in = 8'd0;
    logic [7:0]  b_in = 8'd0;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic        alu_ci, alu_co;
    logic [2:0]  alu_op;
    logic        busy, done, zero, hi_nz;
    logic [15:0] product;

    int checks = 0;
    int failures = 0;

    jalu_mul_seq #(.OP_ADD(OP_ADD), .OP_SHR(OP_SHR)) dut (
        .CLK(CLK), .RST(RST), .start(start), .a_in(a_in), .b_in(b_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci), .alu_op(alu_op),
        .alu_out(alu_out), .alu_co(alu_co), .busy(busy), .done(done),
        .product(product), .zero(zero), .hi_nz(hi_nz)
    );

    always #5 CLK = ~CLK;

    // External ALU
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_ci};
        alu_out = 8'd0;
        alu_co  = 1'b0;
        if (alu_op == OP_ADD) begin
            alu_out = alu_sum[7:0];
            alu_co  = alu_sum[8];
        end else if (alu_op == OP_SHR) begin
            alu_out = {alu_ci, alu_a[7:1]};
            alu_co  = alu_a[0];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase = edges since accept; product is plain a*b at phase 24.
    bit          m_busy = 0;
    int          m_phase = 0;
    int          m_a = 0, m_b = 0;
    int          m_prod = 0;
    bit          m_zero = 1, m_hinz = 0;
    bit          chk_en = 0;
    int          cyc = 0;

    always @(posedge CLK) begin
        cyc++;
        if (RST) begin
            m_busy = 0; m_phase = 0; m_prod = 0; m_zero = 1; m_hinz = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_phase = 0; m_a = int'(a_in); m_b = int'(b_in);
            end
        end else if (m_phase == 24) begin
            m_busy = 0;
        end else begin
            m_phase++;
            if (m_phase == 24) begin
                m_prod = m_a * m_b;
                m_zero = (m_prod == 0);
                m_hinz = (m_prod >= 256);
            end
        end
    end

    // Monitor: outputs and ALU drives every cycle, plus accept/done logging.
    bit prev_busy = 0;
    int done_cnt = 0;
    int acc_cyc[$];

    always @(negedge CLK) begin
        int it, r, p_i, q_i, psum;
        int e_op, e_a, e_b, e_ci;
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, (m_busy && m_phase == 24) ? 1 : 0);
            chk("product", product, m_prod);
            chk("zero", zero, m_zero);
            chk("hi_nz", hi_nz, m_hinz);
            e_op = OP_ADD; e_a = 0; e_b = 0; e_ci = 0;
            if (m_busy && m_phase < 24) begin
                // After it iterations {P,Q} = (a*(b mod 2^it)) << (8-it) | b >> it
                it   = m_phase / 3;
                r    = ((m_a * (m_b % (1 << it))) << (8 - it)) | (m_b >> it);
                p_i  = (r >> 8) & 255;
                q_i  = r & 255;
                psum = p_i + (((m_b >> it) & 1) != 0 ? m_a : 0);
                case (m_phase % 3)
                    0: begin e_a = p_i; e_b = m_a; end
                    1: begin e_op = OP_SHR; e_a = psum & 255; e_ci = psum >> 8; end
                    default: begin e_op = OP_SHR; e_a = q_i; e_ci = psum & 1; end
                endcase
            end
            chk("alu_op", alu_op, e_op);
            chk("alu_a", alu_a, e_a);
            chk("alu_b", alu_b, e_b);
            chk("alu_ci", alu_ci, e_ci);
            if (done) done_cnt++;
            if (busy && !prev_busy) acc_cyc.push_back(cyc);
        end
        prev_busy = busy;
    end

    task automatic run(input logic [7:0] a, input logic [7:0] b, input int exp_prod,
                       input int exp_zero, input int exp_hinz);
        int n;
        @(negedge CLK);
        a_in = a; b_in = b; start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        n = 0;
        while (n < 40) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            if (done) break;
        end
        chk("latency", n, 24);
        @(negedge CLK);
        chk("idle_busy", busy, 0);
        chk("lit_product", product, exp_prod);
        chk("lit_zero", zero, exp_zero);
        chk("lit_hi_nz", hi_nz, exp_hinz);
    endtask

    initial begin
        int d0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        chk_en = 1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_product", product, 0);
        chk("rst_zero", zero, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        run(8'd13, 8'd11, 16'h008F, 0, 0);
        run(8'd255, 8'd255, 16'hFE01, 0, 1);
        run(8'd0, 8'd200, 16'h0000, 1, 0);
        run(8'd200, 8'd0, 16'h0000, 1, 0);
        run(8'd1, 8'd1, 16'h0001, 0, 0);

        // Abort mid-operation with reset
        d0 = done_cnt;
        @(negedge CLK);
        a_in = 8'd13; b_in = 8'd11; start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_product", product, 0);
        repeat (30) @(negedge CLK);
        chk("abort_no_done", done_cnt, d0);
        run(8'd1, 8'd128, 16'h0080, 0, 0);

        // Held start: accepts every 26 cycles only
        acc_cyc.delete();
        d0 = done_cnt;
        @(negedge CLK);
        a_in = 8'd2; b_in = 8'd3; start = 1'b1;
        repeat (60) @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (35) @(negedge CLK);
        chk("held_accepts", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            chk("held_gap1", acc_cyc[1] - acc_cyc[0], 26);
            chk("held_gap2", acc_cyc[2] - acc_cyc[1], 26);
        end
        chk("held_dones", done_cnt - d0, 3);
        chk("held_product", product, 16'h0006);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
